// File: rtl/systolic_feeder.sv
// systolic_feeder
//   Upstream stage of an N x N systolic matrix multiplier. It takes matrix A and then
//   matrix B one row per beat over a valid/ready stream and stores both. It then drives
//   the array edges with diagonally skewed operands, one step per cycle:
//     a_out lane i = A[i][s-i], b_out lane j = B[s-j][j]
//   Each lane is zero outside the diagonal band. The block also pulses array_clear once
//   before feeding, and it raises done until the consumer acknowledges the result.
//
// Handshake: a beat transfers on a rising clock edge where in_valid & in_ready are both 1.
//   in_valid may drop at any time, and loading simply waits. in_ready is 1 only in IDLE
//   and LOAD. Outside those states in_valid is ignored.
//
// Ports
//   clock, reset      rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready input row stream; in_row lane k = bits [(k+1)*W-1 : k*W]
//   hold              downstream stall; freezes the feed step and zeroes the lanes
//   array_clear       one-cycle pulse before the first feed step
//   feed_valid        the array advances this cycle
//   a_out, b_out      west-edge (A) and north-edge (B) operand lanes
//   done, done_ack    result-ready flag, held until it is acknowledged
//   busy              state != IDLE
//   dbg_state         current FSM state, for observation only
//   stall_count       (only with SYSTOLIC_FEEDER_STALLCNT_EN) number of held FEED cycles
//
// Configuration macro: SYSTOLIC_FEEDER_STALLCNT_EN adds the saturating stall_count output.
module systolic_feeder #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_row,
  input  logic           hold,
  output logic           array_clear,
  output logic           feed_valid,
  output logic [N*W-1:0] a_out,
  output logic [N*W-1:0] b_out,
  output logic           done,
  input  logic           done_ack,
  output logic           busy,
  output logic [2:0]     dbg_state
`ifdef SYSTOLIC_FEEDER_STALLCNT_EN
  ,
  output logic [15:0]    stall_count
`endif
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = $clog2(2 * N) > IW ? $clog2(2 * N) : IW;
  localparam int SW = $clog2(3 * N - 1) > BW ? $clog2(3 * N - 1) : BW;
  localparam logic [BW-1:0] LAST_BEAT = BW'(2 * N - 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(3 * N - 3);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CLEAR = 3'd2,
    S_FEED  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [SW-1:0]   step_q, step_d;
  logic            accept;
  logic [BW-1:0]   b_row;
  logic [W-1:0]    a_q [N][N];
  logic [W-1:0]    b_q [N][N];

  // State register and counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      step_q  <= step_d;
    end
  end

  // Next-state logic and control outputs
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    step_d      = step_q;
    accept      = 1'b0;
    in_ready    = 1'b0;
    array_clear = 1'b0;
    feed_valid  = 1'b0;
    done        = 1'b0;
    case (state_q)
      S_IDLE, S_LOAD: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) begin
          if (beat_q == LAST_BEAT) begin
            state_d = S_CLEAR;
            beat_d  = '0;
          end else begin
            state_d = S_LOAD;
            beat_d  = beat_q + 1'b1;
          end
        end
      end
      S_CLEAR: begin
        array_clear = 1'b1;
        state_d     = S_FEED;
        step_d      = '0;
      end
      S_FEED: begin
        if (!hold) begin
          feed_valid = 1'b1;
          if (step_q == LAST_STEP) state_d = S_DONE;
          else                     step_d  = step_q + 1'b1;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (done_ack) begin
          state_d = S_IDLE;
          beat_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

  // Beats 0..N-1 are rows of A; beats N..2N-1 are rows of B.
  assign b_row = beat_q - BW'(N);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_q[r][c] <= '0;
          b_q[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int c = 0; c < N; c++) begin
        if (beat_q < BW'(N)) a_q[beat_q[IW-1:0]][c] <= in_row[c*W +: W];
        else                 b_q[b_row[IW-1:0]][c]  <= in_row[c*W +: W];
      end
    end
  end

  // Skewed lanes. Lane k sees operand index (s - k), and it is valid only while that
  // index lies in [0, N). The same offset serves A row k and B column k.
  for (genvar k = 0; k < N; k++) begin : g_lane
    logic [SW-1:0] off;
    logic          in_band;
    assign off     = step_q - SW'(k);
    assign in_band = feed_valid && (step_q >= SW'(k)) && (off < SW'(N));
    assign a_out[k*W +: W] = in_band ? a_q[k][off[IW-1:0]] : '0;
    assign b_out[k*W +: W] = in_band ? b_q[off[IW-1:0]][k] : '0;
  end

`ifdef SYSTOLIC_FEEDER_STALLCNT_EN
  logic [15:0] stall_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (state_q == S_CLEAR) begin
      stall_q <= '0;
    end else if (state_q == S_FEED && hold && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end
  assign stall_count = stall_q;
`endif

endmodule
